// File: rtl/y86_pkg.sv
// Shared Y86 definitions for the fetch-stage instruction memory:
// instruction codes, fetch window geometry and the load/run state encoding.
package y86_pkg;

   localparam logic [3:0] IHALT   = 4'h0;
   localparam logic [3:0] INOP    = 4'h1;
   localparam logic [3:0] IRRMOVQ = 4'h2;
   localparam logic [3:0] IIRMOVQ = 4'h3;
   localparam logic [3:0] IRMMOVQ = 4'h4;
   localparam logic [3:0] IMRMOVQ = 4'h5;
   localparam logic [3:0] IOPQ    = 4'h6;
   localparam logic [3:0] IJXX    = 4'h7;
   localparam logic [3:0] ICALL   = 4'h8;
   localparam logic [3:0] IRET    = 4'h9;
   localparam logic [3:0] IPUSHQ  = 4'hA;
   localparam logic [3:0] IPOPQ   = 4'hB;

   // Longest Y86 instruction: icode/ifun, register byte, 8-byte constant.
   localparam int FETCH_BYTES = 10;
   localparam int WINDOW_W    = FETCH_BYTES * 8;

   localparam logic [0:0] ST_LOAD = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   function automatic logic [3:0] icode_of(input logic [7:0] first_byte);
      return first_byte[7:4];
   endfunction

endpackage

// File: rtl/instr_mem_fetch_bank_if.sv
// Fetch request/response channel between the fetch stage (master) and the
// instruction memory (slave).
interface instr_mem_fetch_bank_if #(
   parameter int PC_W = 64
);
   logic            req_valid;
   logic            req_ready;
   logic [PC_W-1:0] pc;
   logic            resp_valid;
   logic            resp_ready;
   logic [7:0]      Byte0;
   logic [71:0]     Byte19;
   logic            imem_error;

   modport master (
      output req_valid, pc, resp_ready,
      input  req_ready, resp_valid, Byte0, Byte19, imem_error
   );

   modport slave (
      input  req_valid, pc, resp_ready,
      output req_ready, resp_valid, Byte0, Byte19, imem_error
   );
endinterface

// File: rtl/imem_byte_array.sv
// Byte-wide program storage with a single write port and a combinational
// FETCH_BYTES-wide read window starting at rd_addr (first byte in the MSBs).
module imem_byte_array
   import y86_pkg::*;
#(
   parameter int DEPTH = 2048,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic                clk,
   input  logic                wr_en,
   input  logic [AW-1:0]       wr_addr,
   input  logic [7:0]          wr_data,
   input  logic [AW-1:0]       rd_addr,
   output logic [WINDOW_W-1:0] rd_window
);

   logic [7:0] mem [DEPTH];

   // No reset: program contents must survive a reset of the fetch logic.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   generate
      for (genvar gi = 0; gi < FETCH_BYTES; gi++) begin : g_window
         logic [AW:0] idx;
         assign idx = {1'b0, rd_addr} + (AW+1)'(gi);
         // Bytes past the array end read as zero; the top flags such windows anyway.
         assign rd_window[(FETCH_BYTES-1-gi)*8 +: 8] =
            (idx < (AW+1)'(DEPTH)) ? mem[idx[AW-1:0]] : 8'h00;
      end
   endgenerate

endmodule

// File: rtl/instr_mem_fetch_bank.sv
// Y86 instruction memory: byte-wide program load after reset, then registered
// 10-byte fetch windows over a valid/ready channel with range checking.
module instr_mem_fetch_bank
   import y86_pkg::*;
#(
   parameter int DEPTH       = 2048,
   parameter int PC_W        = 64,
   parameter int LOAD_ADDR_W = 64
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     load_en,
   input  logic [PC_W-1:0]          load_addr,
   input  logic [7:0]               load_data,
   input  logic                     load_last,
   output logic                     load_err,
   output logic                     running,
   instr_mem_fetch_bank_if.slave    fetch
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [PC_W:0]        LAST_PC    = (PC_W+1)'(DEPTH - FETCH_BYTES);
   localparam logic [LOAD_ADDR_W:0] LOAD_LIMIT = (LOAD_ADDR_W+1)'(DEPTH);

   logic [0:0]          state_reg, state_next;
   logic                load_err_reg, load_err_next;
   logic                resp_valid_reg, resp_valid_next;
   logic [7:0]          byte0_reg, byte0_next;
   logic [71:0]         byte19_reg, byte19_next;
   logic                imem_error_reg, imem_error_next;

   logic                in_run;
   logic                req_ready_int;
   logic                accept;
   logic                load_in_range;
   logic                fetch_in_range;
   logic                mem_wr_en;
   logic [WINDOW_W-1:0] window;

   assign in_run        = (state_reg == ST_RUN);
   assign req_ready_int = in_run & (~resp_valid_reg | fetch.resp_ready);
   assign accept        = fetch.req_valid & req_ready_int;

   // Compares are one bit wider than the address so values near all-ones cannot wrap.
   assign load_in_range  = {1'b0, (LOAD_ADDR_W)'(load_addr)} < LOAD_LIMIT;
   assign fetch_in_range = {1'b0, fetch.pc} <= LAST_PC;

   assign mem_wr_en = ~reset & ~in_run & load_en & load_in_range;

   imem_byte_array #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_array (
      .clk       (clk),
      .wr_en     (mem_wr_en),
      .wr_addr   (load_addr[AW-1:0]),
      .wr_data   (load_data),
      .rd_addr   (fetch.pc[AW-1:0]),
      .rd_window (window)
   );

   always_comb begin
      state_next    = state_reg;
      load_err_next = load_err_reg;
      if (!in_run && load_en) begin
         if (!load_in_range) begin
            load_err_next = 1'b1;
         end
         if (load_last) begin
            state_next = ST_RUN;
         end
      end
   end

   always_comb begin
      resp_valid_next = resp_valid_reg;
      byte0_next      = byte0_reg;
      byte19_next     = byte19_reg;
      imem_error_next = imem_error_reg;
      if (accept) begin
         resp_valid_next = 1'b1;
         if (fetch_in_range) begin
            byte0_next      = window[WINDOW_W-1 -: 8];
            byte19_next     = window[71:0];
            imem_error_next = 1'b0;
         end else begin
            byte0_next      = 8'h00;
            byte19_next     = 72'h0;
            imem_error_next = 1'b1;
         end
      end else if (resp_valid_reg && fetch.resp_ready) begin
         // Drained with nothing behind it: data outputs keep their last values.
         resp_valid_next = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg      <= ST_LOAD;
         load_err_reg   <= 1'b0;
         resp_valid_reg <= 1'b0;
         byte0_reg      <= 8'h00;
         byte19_reg     <= 72'h0;
         imem_error_reg <= 1'b0;
      end else begin
         state_reg      <= state_next;
         load_err_reg   <= load_err_next;
         resp_valid_reg <= resp_valid_next;
         byte0_reg      <= byte0_next;
         byte19_reg     <= byte19_next;
         imem_error_reg <= imem_error_next;
      end
   end

   assign running          = in_run;
   assign load_err         = load_err_reg;
   assign fetch.req_ready  = req_ready_int;
   assign fetch.resp_valid = resp_valid_reg;
   assign fetch.Byte0      = byte0_reg;
   assign fetch.Byte19     = byte19_reg;
   assign fetch.imem_error = imem_error_reg;

endmodule

// File: tb/tb_instr_mem_fetch_bank.sv
// Directed bench for instr_mem_fetch_bank: a scoreboard queue holds expected
// fetch responses and a negedge monitor checks each completed handshake.
module tb_instr_mem_fetch_bank;

   typedef struct {
      logic [63:0] pc;
      logic [7:0]  b0;
      logic [71:0] b19;
      logic        err;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        load_en;
   logic [63:0] load_addr;
   logic [7:0]  load_data;
   logic        load_last;
   logic        load_err;
   logic        running;

   int   checks   = 0;
   int   failures = 0;
   exp_t sb_q[$];

   instr_mem_fetch_bank_if #(.PC_W(64)) bus ();

   instr_mem_fetch_bank #(
      .DEPTH       (2048),
      .PC_W        (64),
      .LOAD_ADDR_W (64)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .load_en   (load_en),
      .load_addr (load_addr),
      .load_data (load_data),
      .load_last (load_last),
      .load_err  (load_err),
      .running   (running),
      .fetch     (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Scoreboard monitor: one comparison per completed response handshake.
   always @(negedge clk) begin
      if (reset) begin
         sb_q.delete();
      end else if (bus.resp_valid && bus.resp_ready) begin
         checks++;
         if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL resp_unexpected: got b0=%h b19=%h err=%b, required no response",
                     bus.Byte0, bus.Byte19, bus.imem_error);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            if (bus.Byte0 !== e.b0 || bus.Byte19 !== e.b19 || bus.imem_error !== e.err) begin
               failures++;
               $display("FAIL resp pc=%h: got b0=%h b19=%h err=%b, required b0=%h b19=%h err=%b",
                        e.pc, bus.Byte0, bus.Byte19, bus.imem_error, e.b0, e.b19, e.err);
            end else begin
               $display("resp ok pc=%h b0=%h b19=%h err=%b", e.pc, bus.Byte0, bus.Byte19,
                        bus.imem_error);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [71:0] act, input logic [71:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end else begin
         $display("check ok %s = %h", name, act);
      end
   endtask

   task automatic load(input logic [63:0] a, input logic [7:0] d, input logic last);
      load_en   = 1'b1;
      load_addr = a;
      load_data = d;
      load_last = last;
      tick();
      load_en   = 1'b0;
      load_last = 1'b0;
   endtask

   // Leaves req_valid high so consecutive calls issue back-to-back.
   task automatic issue(input logic [63:0] p, input logic [7:0] b0, input logic [71:0] b19,
                        input logic err);
      exp_t e;
      int   n;
      bus.req_valid = 1'b1;
      bus.pc        = p;
      #1;
      n = 0;
      while (!bus.req_ready && n < 50) begin
         tick();
         n++;
      end
      if (n == 50) begin
         checks++;
         failures++;
         $display("FAIL req_ready_timeout pc=%h: got req_ready=0, required 1 within 50 cycles", p);
      end else begin
         e.pc = p; e.b0 = b0; e.b19 = b19; e.err = err;
         sb_q.push_back(e);
         @(posedge clk);
         #1;
      end
   endtask

   localparam logic [71:0] PROG_B19 = 72'hF8_08_00_00_00_00_00_00_00;
   localparam logic [71:0] TOP_B19  = 72'hA1_A2_A3_A4_A5_A6_A7_A8_A9;

   initial begin
      logic [7:0] prog [10];
      prog = '{8'h30, 8'hF8, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

      reset = 1'b1;
      load_en = 1'b0; load_addr = '0; load_data = '0; load_last = 1'b0;
      bus.req_valid = 1'b0; bus.pc = '0; bus.resp_ready = 1'b1;
      tick();
      tick();
      chk("reset_running",    72'(running),        72'(0));
      chk("reset_load_err",   72'(load_err),       72'(0));
      chk("reset_resp_valid", 72'(bus.resp_valid), 72'(0));
      chk("reset_byte0",      72'(bus.Byte0),      72'(0));
      chk("reset_byte19",     bus.Byte19,          72'(0));
      chk("reset_imem_error", 72'(bus.imem_error), 72'(0));
      reset = 1'b0;

      // Requests during LOAD must be refused.
      bus.req_valid = 1'b1;
      bus.pc        = 64'd0;
      for (int i = 0; i < 9; i++) begin
         #1;
         chk("load_req_ready", 72'(bus.req_ready), 72'(0));
         load(64'(i), prog[i], 1'b0);
         chk("load_resp_valid", 72'(bus.resp_valid), 72'(0));
      end
      load(64'd2048, 8'h55, 1'b0);
      chk("load_err_set", 72'(load_err), 72'(1));
      for (int i = 0; i < 10; i++) begin
         load(64'(2038 + i), 8'(8'hA0 + i), 1'b0);
      end
      chk("running_before_last", 72'(running), 72'(0));
      load(64'd9, prog[9], 1'b1);
      chk("running_after_last", 72'(running), 72'(1));
      chk("load_err_sticky", 72'(load_err), 72'(1));

      // Handover fetch, latency, then range boundaries back-to-back.
      issue(64'd0, 8'h30, PROG_B19, 1'b0);
      chk("latency_resp_valid", 72'(bus.resp_valid), 72'(1));
      issue(64'd2038, 8'hA0, TOP_B19, 1'b0);
      issue(64'd2039, 8'h00, 72'h0, 1'b1);
      issue(64'hFFFF_FFFF_FFFF_FFFA, 8'h00, 72'h0, 1'b1);
      bus.req_valid = 1'b0;
      tick();
      chk("drain_resp_valid", 72'(bus.resp_valid), 72'(0));

      // Loads in RUN are ignored.
      load(64'd0, 8'hFF, 1'b0);
      chk("run_load_err_unchanged", 72'(load_err), 72'(1));
      issue(64'd0, 8'h30, PROG_B19, 1'b0);
      bus.req_valid = 1'b0;
      tick();

      // Backpressure: response held stable, no new accept.
      bus.resp_ready = 1'b0;
      issue(64'd0, 8'h30, PROG_B19, 1'b0);
      bus.pc = 64'd2038;
      for (int i = 0; i < 3; i++) begin
         chk("stall_req_ready",  72'(bus.req_ready),  72'(0));
         chk("stall_resp_valid", 72'(bus.resp_valid), 72'(1));
         chk("stall_byte0",      72'(bus.Byte0),      72'(8'h30));
         chk("stall_byte19",     bus.Byte19,          PROG_B19);
         tick();
      end
      bus.resp_ready = 1'b1;
      issue(64'd2038, 8'hA0, TOP_B19, 1'b0);
      issue(64'd2039, 8'h00, 72'h0, 1'b1);
      bus.req_valid = 1'b0;
      tick();
      tick();

      // Reset while a response is pending; memory must survive.
      bus.resp_ready = 1'b0;
      issue(64'd0, 8'h30, PROG_B19, 1'b0);
      bus.req_valid = 1'b0;
      chk("pre_reset_resp_valid", 72'(bus.resp_valid), 72'(1));
      reset = 1'b1;
      tick();
      reset = 1'b0;
      bus.resp_ready = 1'b1;
      chk("mid_reset_resp_valid", 72'(bus.resp_valid), 72'(0));
      chk("mid_reset_running",    72'(running),        72'(0));
      chk("mid_reset_load_err",   72'(load_err),       72'(0));
      chk("mid_reset_req_ready",  72'(bus.req_ready),  72'(0));
      load(64'd9, 8'h00, 1'b1);
      chk("reload_running", 72'(running), 72'(1));
      issue(64'd0, 8'h30, PROG_B19, 1'b0);
      bus.req_valid = 1'b0;
      tick();
      tick();
      chk("scoreboard_empty", 72'(sb_q.size()), 72'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
